scope_control_fsm: RTL and testbench
====================================

# scope_control_fsm

Front-panel control state machine for the oscilloscope. It consumes the one-cycle press pulses produced by the three button debouncers (UP, DOWN, CENTER) and maintains the user-adjustable acquisition settings: timebase, volts/div, trigger level and trigger edge. Its registered outputs feed the acquisition/trigger logic and the on-screen display. It provides a browse/edit menu with an inactivity timeout.

## Interface
Parameters:
- TRIG_W, 12, trigger level width (matches ADC sample width)
- TRIG_STEP, 64, trigger level increment per press
- TRIG_DEFAULT, 2048, trigger level after reset
- TB_MAX, 7, highest timebase index
- TB_DEFAULT, 3, timebase index after reset
- VD_MAX, 5, highest volts/div index
- VD_DEFAULT, 2, volts/div index after reset
- TIMEOUT_CYCLES, 200000000, EDIT inactivity timeout in CLK cycles (≥2; 2 s at 100 MHz)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET_N  in  1  synchronous active-low reset, sampled on rising CLK
- BTN_UP_DB  in  1  one-cycle press pulse, UP
- BTN_DOWN_DB  in  1  one-cycle press pulse, DOWN
- BTN_CENTER_DB  in  1  one-cycle press pulse, CENTER
- SEL  out  2  selected item: 0 timebase, 1 volts/div, 2 trigger level, 3 trigger edge
- EDIT_MODE  out  1  1 = EDIT state, 0 = BROWSE
- TIMEBASE  out  3  timebase index, 0..TB_MAX
- VOLT_DIV  out  3  volts/div index, 0..VD_MAX
- TRIG_LEVEL  out  TRIG_W  trigger threshold
- TRIG_EDGE  out  1  1 rising, 0 falling
- PARAM_UPDATE  out  1  one-cycle pulse: a setting changed value

## Operation
- Reset values: SEL=0, EDIT_MODE=0, TIMEBASE=TB_DEFAULT, VOLT_DIV=VD_DEFAULT, TRIG_LEVEL=TRIG_DEFAULT, TRIG_EDGE=1, PARAM_UPDATE=0, timeout counter=0. Reset has priority over every input. Reset in EDIT returns the block to BROWSE with all settings at their defaults.
- Input decode per cycle, in priority order:
  - CENTER set: CENTER action only. UP and DOWN are ignored that cycle.
  - Else UP and DOWN both set: no action.
  - Else the single UP or DOWN press.
- BROWSE state:
  - UP: SEL+1, mod 4 (3→0).
  - DOWN: SEL−1, mod 4 (0→3).
  - CENTER: enter EDIT.
  - Settings do not change; PARAM_UPDATE stays 0.
- EDIT state:
  - CENTER: return to BROWSE.
  - UP/DOWN adjust the item selected by SEL; SEL is frozen.
  - SEL=0 (timebase): +1/−1, saturating at 0 and TB_MAX.
  - SEL=1 (volts/div): +1/−1, saturating at 0 and VD_MAX.
  - SEL=2 (trigger level), UP: if TRIG_LEVEL > 2^TRIG_W−1−TRIG_STEP, load 2^TRIG_W−1; else add TRIG_STEP.
  - SEL=2 (trigger level), DOWN: if TRIG_LEVEL < TRIG_STEP, load 0; else subtract TRIG_STEP.
  - No wrap in either direction. Compare before adding, so there is no intermediate overflow.
  - SEL=3 (trigger edge): UP or DOWN toggles TRIG_EDGE.
- PARAM_UPDATE: asserted only when a setting's value actually changes. A press that hits saturation (already at the limit) produces no pulse.
- Timeout counter:
  - Cleared on entry to EDIT and on any accepted press while in EDIT.
  - Otherwise increments each EDIT cycle.
  - When it reaches TIMEOUT_CYCLES−1, the FSM returns to BROWSE and the counter clears.
  - Held at 0 in BROWSE.
  - A press arriving in the same cycle as the timeout wins: it is processed in EDIT and the counter clears.

## Timing
- All outputs are registered.
- A press pulse at edge n updates SEL, EDIT_MODE and the settings at edge n, visible in cycle n+1. PARAM_UPDATE is high for exactly cycle n+1. Latency: 1 cycle.
- Back-to-back pulses on consecutive cycles are each processed (one step per pulse).
- With no presses after entering EDIT, EDIT_MODE falls exactly TIMEOUT_CYCLES cycles after it rose.

## Test plan
- Reset, then 5 UP pulses in BROWSE → SEL sequence 1,2,3,0,1. No PARAM_UPDATE. Settings remain 3,2,2048,1.
- SEL=0, CENTER, then 6 UP pulses → TIMEBASE 4,5,6,7,7,7. PARAM_UPDATE on the first 4 only. Then CENTER → EDIT_MODE=0.
- SEL=2, EDIT, TRIG_LEVEL=4032, UP → 4095; UP again → 4095 with no pulse. From 40, DOWN → 0.
- CENTER and UP in the same cycle while in BROWSE → enter EDIT, SEL unchanged. UP+DOWN in the same cycle while in EDIT → no change, no pulse.
- TIMEOUT_CYCLES=10: enter EDIT, no presses → EDIT_MODE=0 ten cycles later. Repeat with UP on cycle 9 → the step is applied and EDIT is held for 10 further cycles.
- Set TIMEBASE=6 and TRIG_EDGE=0, then assert RESET_N=0 for 1 cycle while in EDIT → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/scope_control_fsm.sv
// ---------------------------------------------------------------------------
// scope_control_fsm
//
// Front-panel control state machine. Consumes one-cycle press pulses from the
// UP / DOWN / CENTER button debouncers and maintains the user-adjustable
// acquisition settings (timebase, volts/div, trigger level, trigger edge)
// through a BROWSE/EDIT menu with an inactivity timeout in EDIT.
//
// Ports:
//   CLK            in   system clock, rising edge
//   RESET_N        in   synchronous active-low reset
//   BTN_UP_DB      in   one-cycle press pulse, UP
//   BTN_DOWN_DB    in   one-cycle press pulse, DOWN
//   BTN_CENTER_DB  in   one-cycle press pulse, CENTER
//   SEL            out  selected item: 0 timebase, 1 volts/div, 2 trig lvl, 3 edge
//   EDIT_MODE      out  1 = EDIT, 0 = BROWSE
//   TIMEBASE       out  timebase index 0..TB_MAX
//   VOLT_DIV       out  volts/div index 0..VD_MAX
//   TRIG_LEVEL     out  trigger threshold
//   TRIG_EDGE      out  1 rising, 0 falling
//   PARAM_UPDATE   out  one-cycle pulse when a setting changed value
// All outputs are registered.
// ---------------------------------------------------------------------------
module scope_control_fsm #(
   parameter int TRIG_W         = 12,
   parameter int TRIG_STEP      = 64,
   parameter int TRIG_DEFAULT   = 2048,
   parameter int TB_MAX         = 7,
   parameter int TB_DEFAULT     = 3,
   parameter int VD_MAX         = 5,
   parameter int VD_DEFAULT     = 2,
   parameter int TIMEOUT_CYCLES = 200000000
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              BTN_UP_DB,
   input  logic              BTN_DOWN_DB,
   input  logic              BTN_CENTER_DB,
   output logic [1:0]        SEL,
   output logic              EDIT_MODE,
   output logic [2:0]        TIMEBASE,
   output logic [2:0]        VOLT_DIV,
   output logic [TRIG_W-1:0] TRIG_LEVEL,
   output logic              TRIG_EDGE,
   output logic              PARAM_UPDATE
);

   // Counter only has to hold 0..TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]        TB_TOP    = 3'(TB_MAX);
   localparam logic [2:0]        VD_TOP    = 3'(VD_MAX);
   localparam logic [TRIG_W-1:0] TRIG_MAXV = '1;
   localparam logic [TRIG_W-1:0] TRIG_STPV = TRIG_W'(TRIG_STEP);
   // Thresholds compared before stepping so the add/subtract never wraps.
   localparam logic [TRIG_W-1:0] TRIG_HI   = TRIG_MAXV - TRIG_STPV;

   typedef enum logic {
      ST_BROWSE = 1'b0,
      ST_EDIT   = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [2:0]        tb_q, tb_d;
   logic [2:0]        vd_q, vd_d;
   logic [TRIG_W-1:0] trig_q, trig_d;
   logic              edge_q, edge_d;
   logic              upd_q, upd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic up_acc, dn_acc;

   // CENTER masks UP/DOWN; UP together with DOWN cancels out.
   assign up_acc = !BTN_CENTER_DB && BTN_UP_DB && !BTN_DOWN_DB;
   assign dn_acc = !BTN_CENTER_DB && BTN_DOWN_DB && !BTN_UP_DB;

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= ST_BROWSE;
         sel_q   <= 2'd0;
         tb_q    <= 3'(TB_DEFAULT);
         vd_q    <= 3'(VD_DEFAULT);
         trig_q  <= TRIG_W'(TRIG_DEFAULT);
         edge_q  <= 1'b1;
         upd_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tb_q    <= tb_d;
         vd_q    <= vd_d;
         trig_q  <= trig_d;
         edge_q  <= edge_d;
         upd_q   <= upd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tb_d    = tb_q;
      vd_d    = vd_q;
      trig_d  = trig_q;
      edge_d  = edge_q;
      upd_d   = 1'b0;
      cnt_d   = '0;

      case (state_q)
         ST_BROWSE: begin
            if (BTN_CENTER_DB)  state_d = ST_EDIT;
            else if (up_acc)    sel_d   = sel_q + 2'd1;
            else if (dn_acc)    sel_d   = sel_q - 2'd1;
         end

         ST_EDIT: begin
            if (BTN_CENTER_DB) begin
               state_d = ST_BROWSE;
            end else if (up_acc || dn_acc) begin
               // Accepted press: adjust selected item, restart timeout.
               // A press in the timeout cycle lands here and wins.
               case (sel_q)
                  2'd0: begin
                     if (up_acc && tb_q != TB_TOP) begin
                        tb_d  = tb_q + 3'd1;
                        upd_d = 1'b1;
                     end else if (dn_acc && tb_q != 3'd0) begin
                        tb_d  = tb_q - 3'd1;
                        upd_d = 1'b1;
                     end
                  end
                  2'd1: begin
                     if (up_acc && vd_q != VD_TOP) begin
                        vd_d  = vd_q + 3'd1;
                        upd_d = 1'b1;
                     end else if (dn_acc && vd_q != 3'd0) begin
                        vd_d  = vd_q - 3'd1;
                        upd_d = 1'b1;
                     end
                  end
                  2'd2: begin
                     if (up_acc) begin
                        trig_d = (trig_q > TRIG_HI) ? TRIG_MAXV : trig_q + TRIG_STPV;
                     end else begin
                        trig_d = (trig_q < TRIG_STPV) ? '0 : trig_q - TRIG_STPV;
                     end
                     upd_d = (trig_d != trig_q);
                  end
                  default: begin
                     edge_d = !edge_q;
                     upd_d  = 1'b1;
                  end
               endcase
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_BROWSE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = ST_BROWSE;
      endcase
   end

   assign SEL          = sel_q;
   assign EDIT_MODE    = (state_q == ST_EDIT);
   assign TIMEBASE     = tb_q;
   assign VOLT_DIV     = vd_q;
   assign TRIG_LEVEL   = trig_q;
   assign TRIG_EDGE    = edge_q;
   assign PARAM_UPDATE = upd_q;

endmodule

// File: tb/tb_scope_control_fsm.sv
module tb_scope_control_fsm;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        BTN_UP_DB = 1'b0;
   logic        BTN_DOWN_DB = 1'b0;
   logic        BTN_CENTER_DB = 1'b0;
   logic [1:0]  SEL;
   logic        EDIT_MODE;
   logic [2:0]  TIMEBASE;
   logic [2:0]  VOLT_DIV;
   logic [11:0] TRIG_LEVEL;
   logic        TRIG_EDGE;
   logic        PARAM_UPDATE;

   int checks = 0;
   int errors = 0;

   scope_control_fsm #(.TIMEOUT_CYCLES(10)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .BTN_UP_DB(BTN_UP_DB), .BTN_DOWN_DB(BTN_DOWN_DB), .BTN_CENTER_DB(BTN_CENTER_DB),
      .SEL(SEL), .EDIT_MODE(EDIT_MODE), .TIMEBASE(TIMEBASE), .VOLT_DIV(VOLT_DIV),
      .TRIG_LEVEL(TRIG_LEVEL), .TRIG_EDGE(TRIG_EDGE), .PARAM_UPDATE(PARAM_UPDATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive buttons for exactly one rising edge.
   task automatic step(input logic u, input logic d, input logic c);
      BTN_UP_DB = u; BTN_DOWN_DB = d; BTN_CENTER_DB = c;
      @(negedge CLK);
      BTN_UP_DB = 1'b0; BTN_DOWN_DB = 1'b0; BTN_CENTER_DB = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sel"},  32'(SEL), 0);
      chk({tag, "_edit"}, 32'(EDIT_MODE), 0);
      chk({tag, "_tb"},   32'(TIMEBASE), 3);
      chk({tag, "_vd"},   32'(VOLT_DIV), 2);
      chk({tag, "_trig"}, 32'(TRIG_LEVEL), 2048);
      chk({tag, "_edge"}, 32'(TRIG_EDGE), 1);
      chk({tag, "_upd"},  32'(PARAM_UPDATE), 0);
   endtask

   initial begin
      logic [1:0] sel_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [2:0] tb_exp  [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
      logic       tbu_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset
      idle(2);
      RESET_N = 1'b1;
      chk_reset_vals("rst");

      // BROWSE: 5 UP -> 1,2,3,0,1 with no update pulse
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         chk($sformatf("browse_up%0d_sel", i), 32'(SEL), 32'(sel_exp[i]));
         chk($sformatf("browse_up%0d_upd", i), 32'(PARAM_UPDATE), 0);
      end
      chk("browse_tb", 32'(TIMEBASE), 3);
      chk("browse_vd", 32'(VOLT_DIV), 2);
      chk("browse_trig", 32'(TRIG_LEVEL), 2048);
      chk("browse_edge", 32'(TRIG_EDGE), 1);
      step(0, 1, 0); chk("browse_dn_sel", 32'(SEL), 0);
      step(0, 1, 0); chk("browse_dn_wrap", 32'(SEL), 3);
      step(1, 0, 0); chk("browse_up_wrap", 32'(SEL), 0);

      // CENTER+UP together in BROWSE: enter EDIT, SEL unchanged
      step(1, 0, 1);
      chk("cu_edit", 32'(EDIT_MODE), 1);
      chk("cu_sel", 32'(SEL), 0);
      chk("cu_tb", 32'(TIMEBASE), 3);

      // Timebase up to saturation
      for (int i = 0; i < 6; i++) begin
         step(1, 0, 0);
         chk($sformatf("tb_up%0d", i), 32'(TIMEBASE), 32'(tb_exp[i]));
         chk($sformatf("tb_up%0d_upd", i), 32'(PARAM_UPDATE), 32'(tbu_exp[i]));
      end
      step(1, 1, 0);
      chk("updn_tb", 32'(TIMEBASE), 7);
      chk("updn_upd", 32'(PARAM_UPDATE), 0);
      chk("updn_edit", 32'(EDIT_MODE), 1);
      step(0, 1, 0);
      chk("tb_dn", 32'(TIMEBASE), 6);
      chk("tb_dn_upd", 32'(PARAM_UPDATE), 1);
      idle(1);
      chk("upd_one_cycle", 32'(PARAM_UPDATE), 0);
      chk("edit_sel_frozen", 32'(SEL), 0);
      step(0, 0, 1);
      chk("exit_edit", 32'(EDIT_MODE), 0);

      // Volts/div saturation both ends
      step(1, 0, 0); chk("sel1", 32'(SEL), 1);
      step(0, 0, 1);
      step(0, 1, 0); chk("vd_dn1", 32'(VOLT_DIV), 1);
      step(0, 1, 0); chk("vd_dn0", 32'(VOLT_DIV), 0);
      chk("vd_dn0_upd", 32'(PARAM_UPDATE), 1);
      step(0, 1, 0); chk("vd_sat0", 32'(VOLT_DIV), 0);
      chk("vd_sat0_upd", 32'(PARAM_UPDATE), 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      chk("vd_sat5", 32'(VOLT_DIV), 5);
      chk("vd_sat5_upd", 32'(PARAM_UPDATE), 0);
      step(0, 0, 1);

      // Trigger level: 2048 + 31*64 = 4032, then clamp to 4095
      step(1, 0, 0); chk("sel2", 32'(SEL), 2);
      step(0, 0, 1);
      for (int i = 0; i < 31; i++) step(1, 0, 0);
      chk("trig_4032", 32'(TRIG_LEVEL), 4032);
      step(1, 0, 0);
      chk("trig_clamp_hi", 32'(TRIG_LEVEL), 4095);
      chk("trig_clamp_hi_upd", 32'(PARAM_UPDATE), 1);
      step(1, 0, 0);
      chk("trig_sat_hi", 32'(TRIG_LEVEL), 4095);
      chk("trig_sat_hi_upd", 32'(PARAM_UPDATE), 0);
      // 4095 - 63*64 = 63, below one step -> clamp to 0
      for (int i = 0; i < 63; i++) step(0, 1, 0);
      chk("trig_63", 32'(TRIG_LEVEL), 63);
      step(0, 1, 0);
      chk("trig_clamp_lo", 32'(TRIG_LEVEL), 0);
      chk("trig_clamp_lo_upd", 32'(PARAM_UPDATE), 1);
      step(0, 1, 0);
      chk("trig_sat_lo", 32'(TRIG_LEVEL), 0);
      chk("trig_sat_lo_upd", 32'(PARAM_UPDATE), 0);
      step(0, 0, 1);

      // Timeout: EDIT lasts exactly 10 cycles with no presses
      step(1, 0, 0); chk("sel3", 32'(SEL), 3);
      step(0, 0, 1);
      chk("to_enter", 32'(EDIT_MODE), 1);
      idle(9);
      chk("to_hold9", 32'(EDIT_MODE), 1);
      idle(1);
      chk("to_expire", 32'(EDIT_MODE), 0);

      // Press in the timeout cycle wins and restarts the count
      step(0, 0, 1);
      idle(9);
      step(1, 0, 0);
      chk("race_edit", 32'(EDIT_MODE), 1);
      chk("race_edge", 32'(TRIG_EDGE), 0);
      chk("race_upd", 32'(PARAM_UPDATE), 1);
      idle(9);
      chk("race_hold", 32'(EDIT_MODE), 1);
      idle(1);
      chk("race_expire", 32'(EDIT_MODE), 0);

      // Reset while in EDIT (with a press present) restores defaults
      step(1, 0, 0); chk("sel0_again", 32'(SEL), 0);
      step(0, 0, 1);
      chk("pre_rst_tb", 32'(TIMEBASE), 6);
      chk("pre_rst_edit", 32'(EDIT_MODE), 1);
      RESET_N = 1'b0;
      step(1, 0, 0);
      RESET_N = 1'b1;
      chk_reset_vals("edit_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
